fifo_occupancy: RTL and testbench
=================================

# fifo_occupancy

Parametrised synchronous FIFO built around a single-write, single-async-read dual-port RAM, with occupancy reporting, programmable almost-full/almost-empty flags and a synchronous flush. It sits between streaming producers and consumers in the IO path (UART, memory-mapped queues), wherever software or flow control needs fill level rather than just full/empty. Optional statistics logic is compiled in for bring-up and debug.

## Interface
- WIDTH, 32: data width in bits.
- LOGDEPTH, 3: log2 of entry count; DEPTH = 2**LOGDEPTH; legal range 1..10.
- AF_THRESH, DEPTH-1: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low; asserts immediately, deasserts synchronously to clk.
- flush  in  1  synchronous clear of all queued entries.
- enq_valid  in  1  producer has data.
- enq_data  in  WIDTH  write data.
- enq_ready  out  1  FIFO can accept.
- deq_valid  out  1  head entry available.
- deq_data  out  WIDTH  head entry (show-ahead).
- deq_ready  in  1  consumer takes head.
- count  out  LOGDEPTH+1  entries currently stored, 0..DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- hwm  out  LOGDEPTH+1  high-water mark of count.
- stall_cnt  out  16  saturating count of cycles with enq_valid && !enq_ready.

## Operation
- Read and write pointers are LOGDEPTH+1 bits; low LOGDEPTH bits address the RAM, MSB is the wrap bit.
- empty: pointers equal. full: low bits equal, MSBs differ. count = wr_ptr - rd_ptr modulo 2**(LOGDEPTH+1).
- enq_ready = !full && !flush; deq_valid = !empty && !flush. Neither depends combinationally on the other side's valid/ready.
- Enqueue fires on enq_valid && enq_ready: RAM written at wr_ptr, wr_ptr increments. Dequeue fires on deq_valid && deq_ready: rd_ptr increments.
- Simultaneous enqueue and dequeue: both fire, count unchanged. When full, enq_ready stays 0 even if a dequeue fires that cycle (no bypass).
- deq_data is the RAM async read at rd_ptr; content is don't-care while deq_valid is 0.
- flush: next edge sets both pointers to 0; handshakes in the flush cycle do not fire. hwm and stall_cnt are not cleared by flush.
- hwm updates to count_next whenever count_next > hwm.
- stall_cnt increments on every cycle with enq_valid && !enq_ready (including flush cycles), saturates at 16'hFFFF.
- Reset outputs: enq_ready 1, deq_valid 0, count 0, almost_full 0, almost_empty 1, hwm 0, stall_cnt 0. Reset mid-operation discards all entries; RAM contents are not cleared.

## Timing
- Write-to-read latency: 1 cycle (entry enqueued at edge N is visible on deq_data with deq_valid=1 after edge N).
- count, almost_full, almost_empty, enq_ready and deq_valid reflect state after the last edge; all are combinational from registered pointers (plus flush for the handshakes).
- Full throughput: one enqueue and one dequeue per cycle sustained.
- Flush takes effect at the edge it is sampled; FIFO is empty the following cycle.

## Configuration
- FIFO_STATS_EN: when defined, hwm and stall_cnt registers are built and behave as above.
- When undefined, hwm and stall_cnt are tied to constant 0; no registers inferred; all other behaviour identical.

## Structure
- Shared package fifo_pkg: count-width helper (LOGDEPTH+1), STALL_CNT_W = 16, STALL_CNT_MAX.
- Parameter legality checks (LOGDEPTH, AF_THRESH, AE_THRESH ranges) are elaboration-time errors.
- Sub-module fifo_ptr: LOGDEPTH+1-bit pointer with increment enable and synchronous clear, instantiated for read and write.
- Storage: existing ASYNC_RAM_DP, port 0 write-only, port 1 read-only.

## Test plan
- Defaults, write 8 words 0x100..0x107 with deq_ready=0 -> enq_ready drops after 8th, count=8, almost_full=1 from count 7; 9th enq_valid held 3 cycles -> stall_cnt=3 (stats on).
- Drain full FIFO with deq_ready=1 -> data 0x100..0x107 in order, deq_valid drops after 8, almost_empty=1 at count 1, count=0.
- Continuous enq+deq for 40 cycles with incrementing data -> count constant, no loss, pointers wrap 5 times, hwm=1.
- Fill to 5, assert flush with enq_valid=deq_ready=1 -> no handshake fires, count=0 next cycle, hwm remains 5.
- rst_n pulled low mid-stream for a non-edge-aligned 3 ns -> outputs reach reset values immediately; first enqueue after release appears on deq_data one cycle later.
- Build without FIFO_STATS_EN, repeat scenario 1 -> hwm=0 and stall_cnt=0 throughout, all other outputs identical.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the occupancy-reporting FIFO.
package fifo_pkg;

  localparam int STALL_CNT_W = 16;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

  // Pointers and count carry one extra bit so a full FIFO is distinguishable from empty.
  function automatic int cnt_w(input int logdepth);
    return logdepth + 1;
  endfunction

endpackage

// File: rtl/ASYNC_RAM_DP.sv
// Dual-port RAM: port 0 synchronous write, port 1 asynchronous read.
module ASYNC_RAM_DP #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] rdata1
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= wdata0;
  end

  assign rdata1 = mem[addr1];

endmodule

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer with increment enable and synchronous clear.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int LOGDEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  inc,
  output logic [LOGDEPTH:0]     ptr
);

  localparam int PW = cnt_w(LOGDEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Clear wins over increment so a flush always lands on an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + PTR_ONE;
  end

endmodule

// File: rtl/fifo_occupancy.sv
// Synchronous FIFO with fill-level reporting, almost flags and flush.
// Define FIFO_STATS_EN to build the hwm / stall_cnt statistics registers.
module fifo_occupancy
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LOGDEPTH  = 3,
  parameter int AF_THRESH = (1 << LOGDEPTH) - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   enq_valid,
  input  logic [WIDTH-1:0]       enq_data,
  output logic                   enq_ready,
  output logic                   deq_valid,
  output logic [WIDTH-1:0]       deq_data,
  input  logic                   deq_ready,
  output logic [LOGDEPTH:0]      count,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [LOGDEPTH:0]      hwm,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int DEPTH = 1 << LOGDEPTH;
  localparam int CW    = cnt_w(LOGDEPTH);
  localparam logic [CW-1:0] AF_LIM = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LIM = CW'(AE_THRESH);

  if (LOGDEPTH < 1 || LOGDEPTH > 10) begin : g_bad_logdepth
    $error("fifo_occupancy: LOGDEPTH must be in 1..10");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_occupancy: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_occupancy: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          enq_fire;
  logic          deq_fire;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOGDEPTH-1:0] == rd_ptr[LOGDEPTH-1:0]) &&
                 (wr_ptr[LOGDEPTH] != rd_ptr[LOGDEPTH]);
  assign count = wr_ptr - rd_ptr;

  // Handshakes depend only on registered pointers and flush, never on the far side.
  assign enq_ready = !full && !flush;
  assign deq_valid = !empty && !flush;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = deq_valid && deq_ready;

  assign almost_full  = (count >= AF_LIM);
  assign almost_empty = (count <= AE_LIM);

  fifo_ptr #(.LOGDEPTH(LOGDEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (enq_fire),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.LOGDEPTH(LOGDEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (deq_fire),
    .ptr   (rd_ptr)
  );

  ASYNC_RAM_DP #(.DW(WIDTH), .AW(LOGDEPTH)) u_ram (
    .clk    (clk),
    .we0    (enq_fire),
    .addr0  (wr_ptr[LOGDEPTH-1:0]),
    .wdata0 (enq_data),
    .addr1  (rd_ptr[LOGDEPTH-1:0]),
    .rdata1 (deq_data)
  );

`ifdef FIFO_STATS_EN
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] count_next;

  always_comb begin
    count_next = count;
    if (flush)                      count_next = '0;
    else if (enq_fire && !deq_fire) count_next = count + CNT_ONE;
    else if (deq_fire && !enq_fire) count_next = count - CNT_ONE;
  end

  // Statistics survive flush; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm       <= '0;
      stall_cnt <= '0;
    end else begin
      if (count_next > hwm) hwm <= count_next;
      if (enq_valid && !enq_ready && stall_cnt != STALL_CNT_MAX)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign hwm       = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_occupancy.sv
// Directed scoreboard bench for fifo_occupancy at default parameters.
`timescale 1ns/100ps
module tb_fifo_occupancy;

  localparam int WIDTH    = 32;
  localparam int LOGDEPTH = 3;
  localparam int DEPTH    = 8;
  localparam int AF       = 7;
  localparam int AE       = 1;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              enq_valid;
  logic [WIDTH-1:0]  enq_data;
  logic              enq_ready;
  logic              deq_valid;
  logic [WIDTH-1:0]  deq_data;
  logic              deq_ready;
  logic [LOGDEPTH:0] count;
  logic              almost_full;
  logic              almost_empty;
  logic [LOGDEPTH:0] hwm;
  logic [15:0]       stall_cnt;

  fifo_occupancy #(.WIDTH(WIDTH), .LOGDEPTH(LOGDEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_data     (enq_data),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_data     (deq_data),
    .deq_ready    (deq_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .hwm          (hwm),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb [$];
  int          mHwm   = 0;
  int          mStall = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic mFull, mRdy, mDv;
    mFull = (sb.size() == DEPTH);
    mRdy  = !mFull && !flush;
    mDv   = (sb.size() != 0) && !flush;
    checkOutput({tag, ".enq_ready"}, 32'(enq_ready), 32'(mRdy));
    checkOutput({tag, ".deq_valid"}, 32'(deq_valid), 32'(mDv));
    checkOutput({tag, ".count"}, 32'(count), 32'(sb.size()));
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(sb.size() >= AF));
    checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(sb.size() <= AE));
    checkOutput({tag, ".hwm"}, 32'(hwm), 32'(mHwm));
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(mStall));
    if (mDv) checkOutput({tag, ".deq_data"}, deq_data, sb[0]);
  endtask

  // One clock: drive, compare pre-edge outputs at negedge, advance the model at the edge.
  task automatic applyStimulus(input string tag, input logic ev, input logic [31:0] ed,
                               input logic dr, input logic fl);
    logic mRdy, mDv;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    flush     = fl;
    @(negedge clk);
    checkAll(tag);
    mRdy = (sb.size() != DEPTH) && !fl;
    mDv  = (sb.size() != 0) && !fl;
`ifdef FIFO_STATS_EN
    if (ev && !mRdy && mStall < 16'hFFFF) mStall++;
`endif
    if (fl) sb.delete();
    else begin
      if (dr && mDv) void'(sb.pop_front());
      if (ev && mRdy) sb.push_back(ed);
    end
`ifdef FIFO_STATS_EN
    if (sb.size() > mHwm) mHwm = sb.size();
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".enq_ready"}, 32'(enq_ready), 32'd1);
    checkOutput({tag, ".deq_valid"}, 32'(deq_valid), 32'd0);
    checkOutput({tag, ".count"}, 32'(count), 32'd0);
    checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'd0);
    checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
    checkOutput({tag, ".hwm"}, 32'(hwm), 32'd0);
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
    #3;
    checkReset("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 32'h108, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("empty", 1'b0, 32'h0, 1'b1, 1'b0);

    d = 32'h200;
    applyStimulus("stream0", 1'b1, d, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      d++;
      applyStimulus("stream", 1'b1, d, 1'b1, 1'b0);
    end
    applyStimulus("stream_end", 1'b0, 32'h0, 1'b1, 1'b0);

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 checkReset("midrst");
    #2 rst_n = 1'b1;
    sb.delete();
    mHwm = 0;
    mStall = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) applyStimulus("fill5", 1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 32'h3FF, 1'b1, 1'b1);
    applyStimulus("post_flush", 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("refill", 1'b1, 32'h400, 1'b0, 1'b0);
    applyStimulus("refill_rd", 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus("final", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
